l1_mem_arbiter: RTL
===================

Name: l1_mem_arbiter

Overview:
- Two-master request arbiter sitting directly upstream of the L1-to-AXI/ACE bridge.
- Merges icache line fetches (path 0) and dcache line reads/writes (path 1) into the bridge's single request port.
- Keeps one transaction outstanding and routes the bridge response back to the owning cache.
- Registers the granted request so the bridge sees stable fields while valid is high.

Parameters:
abits, 48, physical address width (CFG_CPU_ADDR_BITS)
linebits, 256, cache line width in bits (L1CACHE_LINE_BITS)
linebytes, 32, bytes per line, equals linebits/8 (L1CACHE_BYTES_PER_LINE)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_nrst  in  1  synchronous active-low reset
i_i_req_valid  in  1  icache request valid
o_i_req_ready  out  1  icache request accepted
i_i_req_addr  in  abits  icache line address
o_i_resp_valid  out  1  icache response strobe
o_i_resp_data  out  linebits  icache response line
o_i_resp_err  out  1  icache load fault
i_d_req_valid  in  1  dcache request valid
o_d_req_ready  out  1  dcache request accepted
i_d_req_type  in  3  bit0 write, bit1 cached, bit2 unique
i_d_req_addr  in  abits  dcache address
i_d_req_size  in  3  AXI size encoding
i_d_req_wdata  in  linebits  write line
i_d_req_wstrb  in  linebytes  write byte strobes
o_d_resp_valid  out  1  dcache response strobe
o_d_resp_data  out  linebits  dcache response line
o_d_resp_err  out  1  dcache load/store fault
o_mem_req_valid  out  1  request to bridge
i_mem_req_ready  in  1  bridge accepts request
o_mem_req_path  out  1  0 = icache, 1 = dcache
o_mem_req_type  out  3  as i_d_req_type
o_mem_req_addr  out  abits  request address
o_mem_req_size  out  3  request size
o_mem_req_prot  out  3  bit2 = instruction access
o_mem_req_wdata  out  linebits  write line
o_mem_req_wstrb  out  linebytes  write strobes
i_mem_resp_valid  in  1  bridge response strobe
i_mem_resp_path  in  1  path echoed by bridge
i_mem_resp_data  in  linebits  response line
i_mem_resp_load_fault  in  1  read error
i_mem_resp_store_fault  in  1  write error

Behaviour:
- Reset, on i_nrst low at an i_clk edge:
  - state = IDLE, rr_pri = 0 (icache preferred first), all request registers 0.
  - o_mem_req_valid = 0, both req_ready = 0, both resp_valid = 0.
- States:
  - IDLE: ready outputs are combinational in IDLE only.
    - Winner is the sole valid requester; on a tie, the one selected by rr_pri (0 = icache, 1 = dcache).
    - Winner sees req_ready = 1 that cycle; the loser sees 0.
    - On the accept edge, latch fields, set owner = winner, rr_pri = !winner, go to REQ.
  - REQ: o_mem_req_valid = 1 with the latched fields.
    - On i_mem_req_ready = 1, go to RESP. Valid drops the next cycle.
  - RESP: wait for i_mem_resp_valid.
    - Accept the response only if i_mem_resp_path == owner. A mismatched path is ignored and the block stays in RESP.
    - On accept, go to IDLE.
- Icache request fields: type = 3'b010 (cached read), size = 3'd5, wdata = 0, wstrb = 0, prot = 3'b100.
- Dcache request fields: prot = 3'b000; other fields copied from the d inputs.
- Response routing, combinational in the accept cycle, no added latency:
  - resp_valid = i_mem_resp_valid & (owner match) for the owning port; the other port's resp_valid stays 0.
  - resp_data = i_mem_resp_data.
  - resp_err = load_fault | store_fault.
  - Non-owning data outputs hold 0.
- Latency:
  - Accept edge to o_mem_req_valid high: 1 cycle.
  - Bridge response to cache response: 0 cycles.
  - Earliest next grant: the cycle after the response.
- Boundary conditions:
  - No backpressure on responses.
  - A requester dropping valid before its grant is legal and is simply not granted.
  - Request fields are sampled only on the accept edge; later changes are ignored.
  - A response in IDLE or REQ is dropped.
  - Simultaneous request and response in RESP: the response completes first; arbitration occurs in the following IDLE cycle.
  - Reset mid-transaction returns to IDLE and discards the owner. The bridge is reset by the same i_nrst.

Optional Feature:
- Macro: L1_ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority, dcache always wins a tie; rr_pri is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with both valids high → all outputs 0. First IDLE cycle: o_i_req_ready=1, o_d_req_ready=0, path 0 latched, rr_pri=1.
- Icache alone at addr 0x0000_1000_0000; bridge ready after 2 cycles; response data 0xA5…A5 → o_mem_req_type=3'b010, size=5, prot=3'b100; o_i_resp_valid for exactly 1 cycle with that data; o_d_resp_valid=0.
- Dcache write, type=3'b001, wstrb=0xFFFF_0000; response with store_fault=1 → o_d_resp_err=1; wdata/wstrb forwarded bit-exact.
- Both requesting continuously for 6 transactions → grant order I,D,I,D,I,D (macro off) or D,D,D,D,D,D (macro on).
- In RESP owner=1, bridge sends resp with path=0 → ignored, still RESP; next resp with path=1 → delivered to dcache.
- i_nrst low while in REQ → next cycle o_mem_req_valid=0, state IDLE; a late response is dropped.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: two-master arbiter (icache = path 0, dcache = path 1)
// in front of the L1-to-AXI/ACE bridge. One transaction is outstanding at
// a time; the granted request is registered so the bridge sees stable
// fields while o_mem_req_valid is high, and the bridge response is routed
// back combinationally to the owning cache.
//
// Optional build macro: L1_ARB_DCACHE_PRIORITY_EN
//   defined   -> fixed priority, dcache wins every tie (no round-robin flop)
//   undefined -> round-robin tie break, icache preferred first after reset
//
// state | meaning
// IDLE  | no transaction; ready outputs show the combinational grant
// REQ   | latched request presented to the bridge, waiting for ready
// RESP  | request handed off, waiting for a response on the owner's path
module l1_mem_arbiter #(
  parameter int abits     = 48,
  parameter int linebits  = 256,
  parameter int linebytes = 32
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_i_req_valid,
  output logic                 o_i_req_ready,
  input  logic [abits-1:0]     i_i_req_addr,
  output logic                 o_i_resp_valid,
  output logic [linebits-1:0]  o_i_resp_data,
  output logic                 o_i_resp_err,
  input  logic                 i_d_req_valid,
  output logic                 o_d_req_ready,
  input  logic [2:0]           i_d_req_type,
  input  logic [abits-1:0]     i_d_req_addr,
  input  logic [2:0]           i_d_req_size,
  input  logic [linebits-1:0]  i_d_req_wdata,
  input  logic [linebytes-1:0] i_d_req_wstrb,
  output logic                 o_d_resp_valid,
  output logic [linebits-1:0]  o_d_resp_data,
  output logic                 o_d_resp_err,
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic                 o_mem_req_path,
  output logic [2:0]           o_mem_req_type,
  output logic [abits-1:0]     o_mem_req_addr,
  output logic [2:0]           o_mem_req_size,
  output logic [2:0]           o_mem_req_prot,
  output logic [linebits-1:0]  o_mem_req_wdata,
  output logic [linebytes-1:0] o_mem_req_wstrb,
  input  logic                 i_mem_resp_valid,
  input  logic                 i_mem_resp_path,
  input  logic [linebits-1:0]  i_mem_resp_data,
  input  logic                 i_mem_resp_load_fault,
  input  logic                 i_mem_resp_store_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 req_valid_q, req_valid_d;
  logic                 path_q, path_d;
  logic [2:0]           type_q, type_d;
  logic [abits-1:0]     addr_q, addr_d;
  logic [2:0]           size_q, size_d;
  logic [2:0]           prot_q, prot_d;
  logic [linebits-1:0]  wdata_q, wdata_d;
  logic [linebytes-1:0] wstrb_q, wstrb_d;
`ifndef L1_ARB_DCACHE_PRIORITY_EN
  logic                 rr_pri_q, rr_pri_d;
`endif

  logic grant;
  logic win_d;
  logic resp_acc;

  // Arbitration and response routing; readies are gated by reset so a held
  // reset never advertises a grant.
  always_comb begin
`ifdef L1_ARB_DCACHE_PRIORITY_EN
    win_d = i_d_req_valid;
`else
    win_d = i_d_req_valid & (~i_i_req_valid | rr_pri_q);
`endif
    grant    = i_nrst & (state_q == IDLE) & (i_i_req_valid | i_d_req_valid);
    resp_acc = i_nrst & (state_q == RESP) & i_mem_resp_valid &
               (i_mem_resp_path == owner_q);

    o_i_req_ready  = grant & ~win_d;
    o_d_req_ready  = grant & win_d;
    o_i_resp_valid = resp_acc & ~owner_q;
    o_d_resp_valid = resp_acc & owner_q;
    o_i_resp_data  = (resp_acc & ~owner_q) ? i_mem_resp_data : '0;
    o_d_resp_data  = (resp_acc & owner_q) ? i_mem_resp_data : '0;
    o_i_resp_err   = resp_acc & ~owner_q &
                     (i_mem_resp_load_fault | i_mem_resp_store_fault);
    o_d_resp_err   = resp_acc & owner_q &
                     (i_mem_resp_load_fault | i_mem_resp_store_fault);
  end

  // Next-state logic: request fields are captured only on the accept edge.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_valid_d = req_valid_q;
    path_d      = path_q;
    type_d      = type_q;
    addr_d      = addr_q;
    size_d      = size_q;
    prot_d      = prot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
`ifndef L1_ARB_DCACHE_PRIORITY_EN
    rr_pri_d    = rr_pri_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          owner_d     = win_d;
          path_d      = win_d;
`ifndef L1_ARB_DCACHE_PRIORITY_EN
          rr_pri_d    = ~win_d;
`endif
          if (win_d) begin
            type_d  = i_d_req_type;
            addr_d  = i_d_req_addr;
            size_d  = i_d_req_size;
            prot_d  = 3'b000;
            wdata_d = i_d_req_wdata;
            wstrb_d = i_d_req_wstrb;
          end else begin
            type_d  = 3'b010;
            addr_d  = i_i_req_addr;
            size_d  = 3'd5;
            prot_d  = 3'b100;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          state_d     = RESP;
          req_valid_d = 1'b0;
        end
      end
      RESP: begin
        if (resp_acc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      req_valid_q <= 1'b0;
      path_q      <= 1'b0;
      type_q      <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
`ifndef L1_ARB_DCACHE_PRIORITY_EN
      rr_pri_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_valid_q <= req_valid_d;
      path_q      <= path_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      prot_q      <= prot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
`ifndef L1_ARB_DCACHE_PRIORITY_EN
      rr_pri_q    <= rr_pri_d;
`endif
    end
  end

  assign o_mem_req_valid = req_valid_q;
  assign o_mem_req_path  = path_q;
  assign o_mem_req_type  = type_q;
  assign o_mem_req_addr  = addr_q;
  assign o_mem_req_size  = size_q;
  assign o_mem_req_prot  = prot_q;
  assign o_mem_req_wdata = wdata_q;
  assign o_mem_req_wstrb = wstrb_q;

endmodule
